// File: rtl/mac_array_pkg.sv
// Shared types and helpers for the output-stationary MAC array and its PEs.
package mac_array_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

    // Wide enough to hold any ACC_W accumulator plus one product without overflow.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      acc_w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi)
            return hi;
        else if (sum < lo)
            return lo;
        return sum;
    endfunction

    // Cycles for the last beat to travel from the skew inputs to the far corner PE.
    function automatic int flush_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/mac_pe_os.sv
// Output-stationary PE: one accumulator, registered act (rightward) and wgt (downward) forwarding.
module mac_pe_os
    import mac_array_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SAT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] act_i,
    input  logic              act_vld_i,
    input  logic [DATA_W-1:0] wgt_i,
    input  logic              wgt_vld_i,
    output logic [DATA_W-1:0] act_o,
    output logic              act_vld_o,
    output logic [DATA_W-1:0] wgt_o,
    output logic              wgt_vld_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic signed [DATA_W-1:0]   act_s;
    logic signed [DATA_W-1:0]   wgt_s;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [SAT_W-1:0]    prod_x;
    logic signed [SAT_W-1:0]    acc_x;
    logic signed [SAT_W-1:0]    sum_x;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    assign act_s  = act_i;
    assign wgt_s  = wgt_i;
    assign prod   = act_s * wgt_s;
    assign prod_x = SAT_W'(prod);
    assign acc_x  = SAT_W'(acc_q);

    // Wrap mode relies on truncating the wide sum back to ACC_W.
    always_comb begin
        sum_x = (SAT != 0) ? sat_add(acc_x, prod_x, ACC_W) : (acc_x + prod_x);
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (act_vld_i && wgt_vld_i)
            acc_d = sum_x[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            act_o     <= '0;
            act_vld_o <= 1'b0;
            wgt_o     <= '0;
            wgt_vld_o <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            act_o     <= act_i;
            act_vld_o <= act_vld_i;
            wgt_o     <= wgt_i;
            wgt_vld_o <= wgt_vld_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mac_array_os_seq.sv
// Output-stationary systolic MAC array with input skew, tile sequencer and row-wise drain.
module mac_array_os_seq
    import mac_array_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int KLEN_W = 16,
    parameter int SAT    = 0,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KLEN_W-1:0]      k_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] act_in,
    input  logic [COLS*DATA_W-1:0] wgt_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLS*ACC_W-1:0]  out_data,
    output logic [ROW_W-1:0]       out_row,
    output logic                   out_last,
    output logic                   busy,
    output logic                   err
);

    localparam int FL   = flush_len(ROWS, COLS);
    localparam int FL_W = $clog2(FL + 1);

    state_e            state_q;
    logic [KLEN_W-1:0] klen_q;
    logic [KLEN_W-1:0] beat_q;
    logic [FL_W-1:0]   flush_q;
    logic [ROW_W-1:0]  row_q;
    logic              err_q;
    logic              beat_fire;
    logic              clr;

    logic [DATA_W-1:0] a_h  [ROWS][COLS+1];
    logic              av_h [ROWS][COLS+1];
    logic [DATA_W-1:0] w_v  [ROWS+1][COLS];
    logic              wv_v [ROWS+1][COLS];
    logic [ACC_W-1:0]  acc  [ROWS][COLS];

    assign in_ready  = (state_q == LOAD);
    assign beat_fire = in_valid && in_ready;
    assign clr       = (state_q == IDLE) && start && (k_len != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (k_len != '0) begin
                            klen_q  <= k_len;
                            beat_q  <= '0;
                            state_q <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat_fire) begin
                        beat_q <= beat_q + KLEN_W'(1);
                        if (beat_q == klen_q - KLEN_W'(1)) begin
                            flush_q <= '0;
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    flush_q <= flush_q + FL_W'(1);
                    if (flush_q == FL_W'(FL - 1)) begin
                        row_q   <= '0;
                        state_q <= DRAIN;
                    end
                end
                default: begin
                    if (out_ready) begin
                        row_q <= row_q + ROW_W'(1);
                        if (row_q == ROW_W'(ROWS - 1))
                            state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Lane r of activations sees r+1 registers, lane c of weights c+1, so operands meet diagonally.
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        logic [DATA_W-1:0] d_q [r+1];
        logic [r:0]        v_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i <= r; i++) d_q[i] <= '0;
                v_q <= '0;
            end else begin
                d_q[0] <= act_in[r*DATA_W +: DATA_W];
                v_q[0] <= beat_fire;
                for (int i = 1; i <= r; i++) begin
                    d_q[i] <= d_q[i-1];
                    v_q[i] <= v_q[i-1];
                end
            end
        end
        assign a_h[r][0]  = d_q[r];
        assign av_h[r][0] = v_q[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wskew
        logic [DATA_W-1:0] d_q [c+1];
        logic [c:0]        v_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i <= c; i++) d_q[i] <= '0;
                v_q <= '0;
            end else begin
                d_q[0] <= wgt_in[c*DATA_W +: DATA_W];
                v_q[0] <= beat_fire;
                for (int i = 1; i <= c; i++) begin
                    d_q[i] <= d_q[i-1];
                    v_q[i] <= v_q[i-1];
                end
            end
        end
        assign w_v[0][c]  = d_q[c];
        assign wv_v[0][c] = v_q[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            mac_pe_os #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SAT(SAT)) u_pe (
                .clk       (clk),
                .reset     (reset),
                .clr_i     (clr),
                .act_i     (a_h[r][c]),
                .act_vld_i (av_h[r][c]),
                .wgt_i     (w_v[r][c]),
                .wgt_vld_i (wv_v[r][c]),
                .act_o     (a_h[r][c+1]),
                .act_vld_o (av_h[r][c+1]),
                .wgt_o     (w_v[r+1][c]),
                .wgt_vld_o (wv_v[r+1][c]),
                .acc_o     (acc[r][c])
            );
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == DRAIN)
            for (int c = 0; c < COLS; c++) out_data[c*ACC_W +: ACC_W] = acc[row_q][c];
    end

    assign out_valid = (state_q == DRAIN);
    assign out_row   = row_q;
    assign out_last  = (state_q == DRAIN) && (row_q == ROW_W'(ROWS - 1));
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule
